// File: rtl/instr_fetch.sv
// Instruction fetch controller: samples the PC, issues a held read request to
// instruction memory, latches the returned word for decode and pulses the PC
// enable once per completed fetch. A read left outstanding too long raises a
// sticky fault.
//
// state | meaning
// IDLE  | post-reset, captures the first PC on the way into REQ
// REQ   | read outstanding, oMemRead high, address frozen
// HOLD  | instruction held in oIR until decode accepts it
// DRAIN | one dead cycle after a flush so the redirected PC settles
// FAULT | memory never answered; parked until reset
module instr_fetch #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic [31:0] iPC,
  output logic        oPCEn,
  output logic [31:0] oMemAddr,
  output logic        oMemRead,
  input  logic [31:0] iMemData,
  input  logic        iMemRdy,
  output logic [31:0] oIR,
  output logic [31:0] oIRPC,
  output logic        oValid,
  input  logic        iReady,
  input  logic        iFlush,
  output logic        oFault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } state_t;

  // A zero TIMEOUT disables the watchdog entirely.
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       irpc_q, irpc_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // State and datapath registers.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ir_q    <= '0;
      irpc_q  <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      irpc_q  <= irpc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and handshake outputs; flush wins over ready/data in every state.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    ir_d     = ir_q;
    irpc_d   = irpc_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    oPCEn    = 1'b0;
    oMemRead = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
        addr_d  = iPC;
        cnt_d   = '0;
      end
      REQ: begin
        oMemRead = 1'b1;
        if (iFlush) begin
          state_d = DRAIN;
        end else if (iMemRdy) begin
          ir_d    = iMemData;
          irpc_d  = addr_q;
          valid_d = 1'b1;
          oPCEn   = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (TO_EN && (cnt_q == CNT_LAST)) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (iFlush) begin
          valid_d = 1'b0;
          state_d = DRAIN;
        end else if (iReady) begin
          // PC already advanced on the fetch edge, so iPC is the next address.
          valid_d = 1'b0;
          state_d = REQ;
          addr_d  = iPC;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        state_d = REQ;
        addr_d  = iPC;
        cnt_d   = '0;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign oMemAddr = addr_q;
  assign oIR      = ir_q;
  assign oIRPC    = irpc_q;
  assign oValid   = valid_q;
  assign oFault   = fault_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a small PC model advances on oPCEn, fetched
// words are queued when memory answers and checked when decode consumes them.
module tb_instr_fetch;

  logic        iClk = 1'b0;
  logic        nRst;
  logic [31:0] iPC;
  logic        oPCEn;
  logic [31:0] oMemAddr;
  logic        oMemRead;
  logic [31:0] iMemData;
  logic        iMemRdy;
  logic [31:0] oIR;
  logic [31:0] oIRPC;
  logic        oValid;
  logic        iReady;
  logic        iFlush;
  logic        oFault;

  // Second instance with the watchdog disabled, left waiting on memory forever.
  logic        nRst0;
  logic        pcen0, rd0, valid0, fault0;
  logic [31:0] addr0, ir0, irpc0;

  always #5 iClk = ~iClk;

  instr_fetch #(.TIMEOUT(16), .CNT_W(8)) dut (
    .iClk(iClk), .nRst(nRst), .iPC(iPC), .oPCEn(oPCEn), .oMemAddr(oMemAddr),
    .oMemRead(oMemRead), .iMemData(iMemData), .iMemRdy(iMemRdy), .oIR(oIR),
    .oIRPC(oIRPC), .oValid(oValid), .iReady(iReady), .iFlush(iFlush), .oFault(oFault)
  );

  instr_fetch #(.TIMEOUT(0), .CNT_W(8)) dut0 (
    .iClk(iClk), .nRst(nRst0), .iPC(32'h0000_0400), .oPCEn(pcen0), .oMemAddr(addr0),
    .oMemRead(rd0), .iMemData(32'h0), .iMemRdy(1'b0), .oIR(ir0),
    .oIRPC(irpc0), .oValid(valid0), .iReady(1'b1), .iFlush(1'b0), .oFault(fault0)
  );

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fetch_t;

  fetch_t      sb_q[$];
  fetch_t      exp_f;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] pc;
  logic        pe_seen;
  int          pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to the next cycle's drive point; the PC model steps if a pulse was seen.
  task automatic next();
    pe_seen = oPCEn;
    @(negedge iClk);
    if (pe_seen) pc = pc + 32'd4;
    iPC = pc;
  endtask

  // Decode handshake: compare the held word against the scoreboard head.
  task automatic consume(input string tag);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp_f = sb_q.pop_front();
      chk({tag, "_ir"}, oIR, exp_f.ir);
      chk({tag, "_irpc"}, oIRPC, exp_f.pc);
    end
  endtask

  initial begin
    nRst = 1'b0; nRst0 = 1'b0;
    pc = 32'h100; iPC = pc;
    iMemData = '0; iMemRdy = 1'b0; iReady = 1'b0; iFlush = 1'b0;
    repeat (2) @(negedge iClk);
    nRst = 1'b1; nRst0 = 1'b1;
    #1;
    chk("idle_rd", {31'd0, oMemRead}, 32'd0);
    chk("idle_addr", oMemAddr, 32'h0);
    chk("idle_valid", {31'd0, oValid}, 32'd0);
    next(); #1;
    chk("req_rd", {31'd0, oMemRead}, 32'd1);
    chk("req_addr", oMemAddr, 32'h100);
    next(); #1;
    // Reset asserted in the middle of an outstanding request.
    nRst = 1'b0; #1;
    chk("rst_rd", {31'd0, oMemRead}, 32'd0);
    chk("rst_pcen", {31'd0, oPCEn}, 32'd0);
    chk("rst_addr", oMemAddr, 32'h0);
    chk("rst_fault", {31'd0, oFault}, 32'd0);
    next();
    nRst = 1'b1; #1;
    chk("rst_idle_rd", {31'd0, oMemRead}, 32'd0);
    next(); #1;
    chk("rst_req_addr", oMemAddr, 32'h100);

    // Zero-wait fetch from address 0.
    nRst = 1'b0; pc = 32'h0; iPC = pc;
    next(); nRst = 1'b1;
    next(); #1;
    iMemRdy = 1'b1; iMemData = 32'h1234_5678; iReady = 1'b1; #1;
    chk("zw_addr", oMemAddr, 32'h0);
    chk("zw_pcen", {31'd0, oPCEn}, 32'd1);
    sb_q.push_back('{ir: 32'h1234_5678, pc: 32'h0});
    next(); iMemRdy = 1'b0; #1;
    chk("zw_valid", {31'd0, oValid}, 32'd1);
    chk("zw_pcen_off", {31'd0, oPCEn}, 32'd0);
    consume("zw");
    next(); #1;
    chk("zw_next_addr", oMemAddr, 32'h4);

    // Three wait states, then five cycles of decode backpressure.
    iReady = 1'b0; pulses = 0;
    for (int i = 0; i < 3; i++) begin
      chk("ws_addr", oMemAddr, 32'h4);
      chk("ws_rd", {31'd0, oMemRead}, 32'd1);
      pulses += int'(oPCEn);
      next(); #1;
    end
    iMemRdy = 1'b1; iMemData = 32'hA5A5_0004; #1;
    chk("ws_addr4", oMemAddr, 32'h4);
    pulses += int'(oPCEn);
    sb_q.push_back('{ir: 32'hA5A5_0004, pc: 32'h4});
    next(); iMemRdy = 1'b0; iMemData = 32'hFFFF_FFFF; #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, oValid}, 32'd1);
      chk("bp_ir", oIR, 32'hA5A5_0004);
      chk("bp_rd", {31'd0, oMemRead}, 32'd0);
      pulses += int'(oPCEn);
      next(); #1;
    end
    iReady = 1'b1; #1;
    consume("bp");
    chk("bp_pulses", pulses, 32'd1);
    next(); #1;
    chk("bp_next_addr", oMemAddr, 32'h8);

    // Flush during REQ with memory answering in the same cycle.
    pc = 32'h200; iPC = pc;
    iFlush = 1'b1; iMemRdy = 1'b1; iMemData = 32'hBAD0_0008; #1;
    chk("fr_pcen", {31'd0, oPCEn}, 32'd0);
    next(); iFlush = 1'b0; iMemRdy = 1'b0; #1;
    chk("fr_drain_rd", {31'd0, oMemRead}, 32'd0);
    chk("fr_drain_valid", {31'd0, oValid}, 32'd0);
    next(); #1;
    chk("fr_req_addr", oMemAddr, 32'h200);
    chk("fr_req_valid", {31'd0, oValid}, 32'd0);

    // Flush during HOLD while decode is ready: held word is dropped.
    iReady = 1'b0; iMemRdy = 1'b1; iMemData = 32'hDEAD_BEEF; #1;
    chk("fh_pcen", {31'd0, oPCEn}, 32'd1);
    next(); iMemRdy = 1'b0; #1;
    chk("fh_valid", {31'd0, oValid}, 32'd1);
    chk("fh_pc_model", iPC, 32'h204);
    pc = 32'h300; iPC = pc; iFlush = 1'b1; iReady = 1'b1; #1;
    next(); iFlush = 1'b0; #1;
    chk("fh_drop_valid", {31'd0, oValid}, 32'd0);
    chk("fh_drain_rd", {31'd0, oMemRead}, 32'd0);
    next(); #1;
    chk("fh_req_addr", oMemAddr, 32'h300);

    // Back-to-back zero-wait fetches: REQ, HOLD alternate.
    for (int i = 0; i < 4; i++) begin
      chk("tp_addr", oMemAddr, 32'h300 + 32'(4 * i));
      iMemRdy = 1'b1; iMemData = 32'hC0DE_0000 | 32'(i); #1;
      chk("tp_pcen", {31'd0, oPCEn}, 32'd1);
      sb_q.push_back('{ir: 32'hC0DE_0000 | 32'(i), pc: 32'h300 + 32'(4 * i)});
      next(); iMemRdy = 1'b0; #1;
      chk("tp_hold_rd", {31'd0, oMemRead}, 32'd0);
      consume("tp");
      next(); #1;
    end
    chk("tp_sb_left", sb_q.size(), 32'd0);

    // Timeout: 16 unanswered REQ cycles then a sticky fault.
    for (int i = 0; i < 16; i++) begin
      chk("to_rd", {31'd0, oMemRead}, 32'd1);
      chk("to_nofault", {31'd0, oFault}, 32'd0);
      next(); #1;
    end
    chk("to_fault", {31'd0, oFault}, 32'd1);
    chk("to_fault_rd", {31'd0, oMemRead}, 32'd0);
    iFlush = 1'b1; iMemRdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next(); #1;
      chk("to_sticky", {31'd0, oFault}, 32'd1);
      chk("to_sticky_rd", {31'd0, oMemRead}, 32'd0);
    end
    iFlush = 1'b0; iMemRdy = 1'b0;
    nRst = 1'b0; #1;
    chk("to_rst_clear", {31'd0, oFault}, 32'd0);
    next(); nRst = 1'b1;

    // Watchdog disabled: the second instance must still be waiting.
    repeat (1000) @(negedge iClk);
    #1;
    chk("to0_nofault", {31'd0, fault0}, 32'd0);
    chk("to0_rd", {31'd0, rd0}, 32'd1);
    chk("to0_addr", addr0, 32'h400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch controller. It is the consumer of the program counter. It samples the current PC and issues a read to instruction memory, then waits for the memory ready handshake. It latches the returned word into an instruction register for decode, and pulses the PC enable so the counter advances by exactly one instruction per completed fetch. It sits between the PC block, the instruction memory port and the decode stage.

Parameters:
TIMEOUT, 16, max cycles a read may stay outstanding before fault; 0 disables the check
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
iClk  in  1  clock, rising edge
nRst  in  1  asynchronous active-low reset
iPC  in  32  current PC value from the PC block
oPCEn  out  1  one-cycle pulse; drives the PC enable to advance PC
oMemAddr  out  32  instruction memory read address (registered)
oMemRead  out  1  memory read request, held until iMemRdy
iMemData  in  32  memory read data, valid when iMemRdy=1
iMemRdy  in  1  memory ready/data-valid strobe
oIR  out  32  latched instruction word
oIRPC  out  32  address the oIR word was fetched from
oValid  out  1  oIR/oIRPC hold an instruction not yet consumed
iReady  in  1  decode accepts oIR when oValid&iReady
iFlush  in  1  PC redirected this cycle (jump/branch); discard in-flight and held fetch
oFault  out  1  sticky fetch timeout flag

Behaviour:
- States: IDLE, REQ, HOLD, DRAIN, FAULT. State is a registered FSM.
- Reset (async, nRst=0):
  - state=IDLE.
  - oMemAddr=0, oIR=0, oIRPC=0, oValid=0, oFault=0, timeout counter=0.
  - oPCEn=0 and oMemRead=0 are combinational and follow from state=IDLE.
  - Reset asserted mid-request drops oMemRead immediately; no PC pulse.
- IDLE: next cycle -> REQ. oMemAddr<=iPC on that transition.
- Every entry into REQ (from IDLE, HOLD or DRAIN) loads oMemAddr<=iPC and clears the counter.
- REQ:
  - oMemRead=1. oMemAddr is stable for the whole request.
  - If iFlush=1: -> DRAIN. Any iMemData this cycle is discarded; oPCEn=0.
  - Else if iMemRdy=1:
    - oIR<=iMemData, oIRPC<=oMemAddr, oValid<=1.
    - oPCEn=1 (combinational, same cycle), so the PC advances on the same edge.
    - -> HOLD.
  - Else the counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no iMemRdy -> FAULT.
- Memory latency: iMemRdy may arrive in the first REQ cycle (zero wait) or any later cycle.
- HOLD:
  - oMemRead=0, oValid=1.
  - If iFlush=1: oValid<=0, -> DRAIN (the held instruction is dropped).
  - Else if iReady=1: oValid<=0, -> REQ, latching the already-advanced iPC.
  - Else remain in HOLD; oIR and oIRPC are stable.
- DRAIN: one idle cycle so the redirected PC settles; oMemRead=0, oValid=0; -> REQ.
- FAULT: oFault=1 and oMemRead=0. Remain until reset; iFlush is ignored.
- oPCEn is asserted only in REQ with iMemRdy=1 and iFlush=0. It is never high for two consecutive cycles.
- iFlush has priority over iMemRdy and iReady in the same cycle.
- Throughput: with zero-wait memory and iReady tied high, the cycle pattern is REQ, HOLD, REQ, HOLD: one instruction per 2 cycles.
- oIRPC+4 equals the PC value after the pulse. There is no address arithmetic inside the block; wrap-around at 0xFFFFFFFC is the PC block's concern.

Test Plan:
- Reset: nRst=0 mid-REQ with iPC=0x100.
  -> outputs immediately 0, oMemRead=0.
  -> after release: IDLE, then REQ with oMemAddr=0x100.
- Zero-wait fetch: iPC=0x0, iMemRdy=1 on the first REQ cycle, iMemData=0x12345678, iReady=1.
  -> oPCEn pulses 1 cycle.
  -> next cycle oIR=0x12345678, oIRPC=0x0, oValid=1.
  -> the following REQ uses oMemAddr=0x4.
- Wait states plus backpressure: iMemRdy delayed 3 cycles, iReady=0 for 5 cycles.
  -> oMemAddr held for 4 REQ cycles.
  -> oValid and oIR stable for 5 cycles; exactly one oPCEn pulse.
- Flush during REQ with iMemRdy=1 in the same cycle, iPC redirected to 0x200.
  -> no oPCEn, oValid stays 0.
  -> DRAIN for 1 cycle, then REQ with oMemAddr=0x200.
- Flush during HOLD with iReady=1.
  -> oValid drops; instruction not counted as consumed; DRAIN then REQ.
- Timeout: TIMEOUT=16, iMemRdy held 0.
  -> oFault=1 after 16 REQ cycles, oMemRead=0, sticky until nRst.
  -> with TIMEOUT=0, no fault after 1000 cycles.
